// File: rtl/mem_berger_scrub_pkg.sv
// Shared types and helpers for the Berger-code protected memory.
// Holds the check-width helper, the check function and the scrub FSM states.
package mem_berger_pkg;

    localparam int unsigned MAX_DW = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CHK
    } scrub_state_e;

    function automatic int unsigned check_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

    // Caller zero-extends the data word; padding bits add no ones.
    function automatic logic [7:0] berger_check(input logic [MAX_DW-1:0] data,
                                                input int unsigned dw,
                                                input bit count_ones);
        logic [7:0] ones;
        ones = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            ones = ones + 8'(data[i]);
        end
        return count_ones ? ones : (8'(dw) - ones);
    endfunction

endpackage

// File: rtl/mem_berger_scrub_if.sv
// Host-side bus of the Berger-protected memory: access port, fault injection and error log.
interface mem_berger_scrub_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4,
    parameter int unsigned CW = 4
);
    logic           wr_en;
    logic           rd_en;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data_in;
    logic [DW+CW-1:0] inj_mask;
    logic [DW-1:0]  rd_data;
    logic           rd_valid;
    logic           rd_err;
    logic           scrub_en;
    logic           err_clr;
    logic [AW-1:0]  err_addr;
    logic           err_addr_valid;
    logic [7:0]     err_cnt;

    modport master (
        output wr_en, rd_en, addr, data_in, inj_mask, scrub_en, err_clr,
        input  rd_data, rd_valid, rd_err, err_addr, err_addr_valid, err_cnt
    );

    modport slave (
        input  wr_en, rd_en, addr, data_in, inj_mask, scrub_en, err_clr,
        output rd_data, rd_valid, rd_err, err_addr, err_addr_valid, err_cnt
    );

endinterface

// File: rtl/mem_berger_scrub_enc.sv
// Combinational Berger check generator (ones count or zero count of the data word).
module berger_enc
    import mem_berger_pkg::*;
#(
    parameter int unsigned DW         = 8,
    parameter bit          COUNT_ONES = 1'b1,
    parameter int unsigned CW         = check_width(DW)
) (
    input  logic [DW-1:0] data,
    output logic [CW-1:0] check
);

    always_comb begin
        check = CW'(berger_check(MAX_DW'(data), DW, COUNT_ONES));
    end

endmodule

// File: rtl/mem_berger_scrub.sv
// Single-port RAM storing {check, data} Berger codewords, with read-time error detection
// and an idle-cycle background scrubber that logs the first failing address.
module mem_berger_scrub
    import mem_berger_pkg::*;
#(
    parameter int unsigned DW         = 8,
    parameter int unsigned DEPTH      = 16,
    parameter bit          COUNT_ONES = 1'b1,
    parameter int unsigned AW         = $clog2(DEPTH),
    parameter int unsigned CW         = check_width(DW)
) (
    input logic               clk,
    input logic               rst,
    mem_berger_scrub_if.slave bus
);

    localparam int unsigned WW = DW + CW;
    localparam logic [CW-1:0] ZERO_CHECK = COUNT_ONES ? '0 : CW'(DW);
    localparam logic [WW-1:0] ZERO_WORD  = {ZERO_CHECK, {DW{1'b0}}};

    logic [WW-1:0] mem [DEPTH];

    logic          port_busy;
    logic          host_rd;
    logic          ptr_hit;
    logic [CW-1:0] wr_check;

    logic [WW-1:0] rd_word_q;
    logic          rd_pend_q;
    logic [AW-1:0] rd_addr_q;

    logic [WW-1:0] chk_word;
    logic [CW-1:0] chk_calc;
    logic          chk_mismatch;

    scrub_state_e  state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] scrub_word_q, scrub_word_d;
    logic          scrub_err_q, scrub_err_d;
    logic          discard_q, discard_d;
    logic          scrub_log;
    logic          host_log;

    logic [1:0]    err_inc;
    logic [8:0]    cnt_sum;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic          err_valid_q, err_valid_d;

    assign port_busy = bus.wr_en | bus.rd_en;
    assign host_rd   = bus.rd_en & ~bus.wr_en;
    assign ptr_hit   = bus.wr_en && (bus.addr == ptr_q);

    berger_enc #(
        .DW         (DW),
        .COUNT_ONES (COUNT_ONES),
        .CW         (CW)
    ) u_enc_wr (
        .data  (bus.data_in),
        .check (wr_check)
    );

    // Read results own the shared checker; the scrubber only compares in cycles without one.
    assign chk_word     = rd_pend_q ? rd_word_q : scrub_word_q;
    assign chk_mismatch = (chk_word[WW-1:DW] != chk_calc);

    berger_enc #(
        .DW         (DW),
        .COUNT_ONES (COUNT_ONES),
        .CW         (CW)
    ) u_enc_chk (
        .data  (chk_word[DW-1:0]),
        .check (chk_calc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= ZERO_WORD;
            end
        end else if (bus.wr_en) begin
            mem[bus.addr] <= {wr_check, bus.data_in} ^ bus.inj_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word_q <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_pend_q <= host_rd;
            if (host_rd) begin
                rd_word_q <= mem[bus.addr];
                rd_addr_q <= bus.addr;
            end
        end
    end

    assign bus.rd_data  = rd_word_q[DW-1:0];
    assign bus.rd_valid = rd_pend_q;
    assign host_log     = rd_pend_q & chk_mismatch;
    assign bus.rd_err   = host_log;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            scrub_word_q <= '0;
            scrub_err_q  <= 1'b0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            scrub_word_q <= scrub_word_d;
            scrub_err_q  <= scrub_err_d;
            discard_q    <= discard_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        scrub_word_d = scrub_word_q;
        scrub_err_d  = scrub_err_q;
        discard_d    = discard_q;
        scrub_log    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.scrub_en && !port_busy) begin
                    state_d      = S_RD;
                    scrub_word_d = mem[ptr_q];
                    discard_d    = 1'b0;
                end
            end
            S_RD: begin
                // A write to the word under test makes the latched copy stale.
                if (ptr_hit) begin
                    discard_d = 1'b1;
                end
                if (!port_busy && !rd_pend_q) begin
                    scrub_err_d = chk_mismatch;
                    state_d     = S_CHK;
                end
            end
            S_CHK: begin
                state_d = S_IDLE;
                if (!discard_q && !ptr_hit) begin
                    scrub_log = scrub_err_q;
                    ptr_d     = ptr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_inc = {1'b0, host_log} + {1'b0, scrub_log};
    assign cnt_sum = {1'b0, err_cnt_q} + {7'd0, err_inc};

    always_comb begin
        err_cnt_d   = err_cnt_q;
        err_addr_d  = err_addr_q;
        err_valid_d = err_valid_q;
        if (bus.err_clr) begin
            err_cnt_d   = '0;
            err_valid_d = 1'b0;
        end else if (host_log || scrub_log) begin
            err_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
            if (!err_valid_q) begin
                err_valid_d = 1'b1;
                err_addr_d  = host_log ? rd_addr_q : ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            err_valid_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign bus.err_cnt        = err_cnt_q;
    assign bus.err_addr       = err_addr_q;
    assign bus.err_addr_valid = err_valid_q;

endmodule
